// File: rtl/seq_mult_ctrl_pkg.sv
// Shared types and constants for the sequential multiplier.
// Holds the FSM state encoding and the default operand width.
package seq_mult_ctrl_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/seq_mult_datapath.sv
// Shift-and-add accumulator: one partial-product step per step pulse.
// Ports: clk, rst, i_load, i_step, i_a, i_b -> o_prod (post-step product).
module seq_mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_prod
);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH:0]   w_sum;

  // acc_lo starts as the multiplier, so its LSB selects each add
  assign w_sum = r_lo[0] ? (r_hi + {1'b0, r_mcand}) : r_hi;

  // Value the accumulator takes on this step; the shift drops the
  // zero carry bit, so the low 2*WIDTH bits are the full product.
  assign o_prod = {w_sum, r_lo[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (i_load) begin
      r_mcand <= i_a;
      r_hi    <= '0;
      r_lo    <= i_b;
    end else if (i_step) begin
      {r_hi, r_lo} <= {1'b0, w_sum, r_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential unsigned multiplier: FSM, step counter, product register.
// Ports: clk, rst, start, A, B -> busy, done, R (all outputs registered).
module seq_mult_ctrl
  import seq_mult_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] R
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             w_load;
  logic             w_step;
  logic [2*WIDTH-1:0] w_prod;

  assign w_load = (r_state == S_IDLE) && start;
  assign w_step = (r_state == S_RUN);

  seq_mult_datapath #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_step(w_step),
    .i_a   (A),
    .i_b   (B),
    .o_prod(w_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      R       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          // the edge finishing step WIDTH latches the product
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            done    <= 1'b1;
            R       <= w_prod;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl at WIDTH=4.
// Hand-computed products, latency, abort and back-to-back checks.
module tb_seq_mult_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       busy;
  logic       done;
  logic [7:0] R;

  int n_cmp = 0;
  int n_bad = 0;

  seq_mult_ctrl #(
    .WIDTH(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .R    (R)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Accept at the next edge, scramble operands, time the done pulse.
  task automatic run_job(input logic [3:0] a,
                         input logic [3:0] b,
                         input logic [7:0] exp,
                         input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = b ^ 4'h5;
    check({tag, "_busy"}, 32'(busy), 1);
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check({tag, "_R"}, 32'(R), 32'(exp));
    @(posedge clk); #1;
    check({tag, "_dn0"}, 32'(done), 0);
    check({tag, "_idle"}, 32'(busy), 0);
    check({tag, "_hold"}, 32'(R), 32'(exp));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dcnt;
    rst = 1'b1; start = 1'b0; A = 4'h0; B = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_R", 32'(R), 0);
    @(posedge clk); #1;
    check("rst_start_ign", 32'(busy), 0);
    start = 1'b0;
    rst = 1'b0;

    run_job(4'hF, 4'hF, 8'hE1, "ff");
    run_job(4'h9, 4'h6, 8'h36, "96");
    repeat (3) begin
      @(negedge clk); A = 4'hA; B = 4'hC;
    end
    @(posedge clk); #1;
    check("96_idle_hold", 32'(R), 32'h36);
    run_job(4'h0, 4'hB, 8'h00, "0b");

    // start re-asserted during RUN must be ignored
    @(negedge clk);
    start = 1'b1; A = 4'h2; B = 4'h5;
    @(posedge clk); #1;
    A = 4'h3; B = 4'h3;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("ign_lat", n, 4);
    check("ign_R", 32'(R), 32'h0A);
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done) dcnt++;
      if (busy) dcnt += 16;
    end
    check("ign_nojob", dcnt, 0);
    check("ign_R_hold", 32'(R), 32'h0A);

    // reset mid-RUN aborts
    @(negedge clk);
    start = 1'b1; A = 4'h7; B = 4'h7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_R", 32'(R), 0);
    dcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_nodone", dcnt, 0);
    check("abort_R2", 32'(R), 0);
    run_job(4'h7, 4'h7, 8'h31, "77");

    // start held high: one job every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; A = 4'h5; B = 4'h5;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_first", 32'(R), 32'h19);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(posedge clk); #1;
        n++;
      end while (!done && n < 20);
      check($sformatf("b2b_per%0d", k), n, 6);
      check($sformatf("b2b_R%0d", k), 32'(R), 32'h19);
    end
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_stop", 32'(busy), 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_job(4'(a), 4'(b), 8'(a * b),
                $sformatf("sw_%0h_%0h", a, b));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mult_ctrl.md
SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  single clock for all flops, rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 Port: A  input  WIDTH  multiplicand; captured on the accepting edge.
REQ-006 Port: B  input  WIDTH  multiplier; captured on the accepting edge.
REQ-007 Port: busy  output  1  high while the state is RUN or DONE.
REQ-008 Port: done  output  1  single-cycle pulse marking that R holds a new product.
REQ-009 Port: R  output  2*WIDTH  unsigned product; held until the next accepted start.

Function
REQ-010 The block SHALL implement unsigned shift-and-add multiplication with exactly one partial-product step per clock.
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE, with the encoding taken from the shared package.
REQ-012 In IDLE with start=1, the next edge SHALL capture A and B, clear the accumulator, set step count=0 and enter RUN ("accept").
REQ-013 In IDLE with start=0, the state, accumulator and R SHALL all hold.
REQ-014 On each RUN edge: if multiplier LSB=1, acc_hi (WIDTH+1 bits including carry) SHALL take acc_hi+multiplicand; then {acc_hi,acc_lo} SHALL shift right by 1; count SHALL increment.
REQ-015 The RUN edge that completes step WIDTH SHALL write R from the accumulator and enter DONE.
REQ-016 done SHALL be 1 only while in DONE; DONE SHALL always go to IDLE on the next edge.
REQ-017 Latency SHALL be fixed: done is high in the cycle after edge WIDTH, counting the accepting edge as edge 0; for WIDTH=4, accept at edge 0 gives done after edge 4.
REQ-018 start SHALL be ignored in RUN and DONE, with no queuing and no operand capture.
REQ-019 A start held high continuously SHALL be accepted on the DONE->IDLE edge plus one, i.e. one idle cycle between jobs.
REQ-020 A and B SHALL be don't-care except on the accepting edge; changes during RUN SHALL NOT affect the result.
REQ-021 R SHALL equal A*B exactly with no truncation; the maximum value is (2^WIDTH-1)^2.
REQ-022 The step counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL NOT wrap within a job.

Reset
REQ-023 While rst=1: state=IDLE, busy=0, done=0, R=0, accumulator=0, count=0, captured operands=0.
REQ-024 Reset asserted mid-RUN or in DONE SHALL abort the job immediately, with no done pulse and R cleared to 0.
REQ-025 The first accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-026 The shared package SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-027 The FSM and counter SHALL live in seq_mult_ctrl; the accumulator/add/shift SHALL be one sub-module, seq_mult_datapath, with controls load, step and product output.
REQ-028 No combinational path SHALL exist from start, A or B to busy, done or R.

Verification
REQ-029 WIDTH=4, A=0xF, B=0xF, start pulse -> busy=1 the next cycle; done pulse after edge 4; R=0xE1.
REQ-030 A=0x9, B=0x6 -> R=0x36; then A=0x0, B=0xB -> R=0x00, with done each time and R holding between jobs.
REQ-031 start re-asserted with A=0x3, B=0x3 during RUN of 0x2*0x5 -> R=0x0A, a single done, no second job.
REQ-032 rst pulsed after edge 2 of a 0x7*0x7 job -> busy=0, done never pulses, R=0x00; a new 0x7*0x7 job then gives R=0x31.
REQ-033 start held high with A=0x5, B=0x5 -> done pulses every WIDTH+2 cycles, and R=0x19 each time.
REQ-034 Exhaustive sweep of all 256 A/B pairs at WIDTH=4 -> R=A*B, with latency checked on every job.
